// File: rtl/uart_mon_pkg.sv
// uart_mon_pkg: FSM state type and default parameters shared by the UART TX frame monitor.
package uart_mon_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int STALL_LIMIT_DEF = 32;
endpackage

// File: rtl/uart_mon_fifo.sv
// uart_mon_fifo: shadow FIFO of bytes written to the TX register, awaiting comparison.
module uart_mon_fifo
    import uart_mon_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0] r_cnt;
    logic w_pop, w_push;
    assign empty_o = r_cnt == '0;
    assign full_o = r_cnt == (AW+1)'(DEPTH);
    assign head_o = r_mem[r_rd];
    assign w_pop = pop_i && !empty_o;
    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign w_push = push_i && (!full_o || w_pop);
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= data_i;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr <= '0;
            r_rd <= '0;
            r_cnt <= '0;
        end else begin
            r_wr <= r_wr + AW'(w_push);
            r_rd <= r_rd + AW'(w_pop);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/uart_tx_frame_monitor.sv
// uart_tx_frame_monitor: decodes the TX line, checks frames against written bytes, keeps sticky error flags.
// Defining UART_MON_STALL_EN adds the tx_busy stall counter and stall_o.
module uart_tx_frame_monitor
    import uart_mon_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] wdata_i,
    input  logic       wdata_qe_i,
    input  logic       tx_i,
    input  logic       tx_busy_i,
    input  logic       clear_i,
    output logic       frame_valid_o,
    output logic [7:0] frame_data_o,
    output logic [7:0] exp_data_o,
    output logic       mismatch_o,
    output logic       frame_err_o,
    output logic       unexpected_o,
    output logic       ovf_o,
    output logic       stall_o,
    output logic       alert_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    state_e r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0] r_bit;
    logic [7:0] r_shift, r_fdata, r_exp;
    logic r_tx, r_valid;
    logic [3:0] r_flags;
    logic w_tick, w_half, w_done, w_pop, w_full, w_empty;
    logic [7:0] w_head;
    logic [3:0] w_set;
    assign w_tick = r_cnt == CW'(CLKS_PER_BIT - 1);
    assign w_half = r_cnt == CW'(CLKS_PER_BIT / 2 - 1);
    assign w_done = (r_state == STOP) && w_tick;
    assign w_pop = w_done && !w_empty;
    // Flag order: mismatch, frame error, unexpected, overflow.
    assign w_set = {w_pop && (w_head != r_shift), w_done && !r_tx, w_done && w_empty,
                    wdata_qe_i && w_full && !w_pop};
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (r_tx && !tx_i) ? START : IDLE;
            START:   w_next = w_half ? (r_tx ? IDLE : DATA) : START;
            DATA:    w_next = (w_tick && r_bit == 3'd7) ? STOP : DATA;
            STOP:    w_next = w_tick ? IDLE : STOP;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_tx <= 1'b1;
            r_cnt <= '0;
            r_bit <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_fdata <= '0;
            r_exp <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_next;
            r_tx <= tx_i;
            r_cnt <= (r_state == IDLE || r_state != w_next || w_tick) ? '0 : r_cnt + 1'b1;
            r_bit <= (r_state == DATA) ? r_bit + 3'(w_tick) : 3'd0;
            if (r_state == DATA && w_tick) r_shift <= {r_tx, r_shift[7:1]};
            r_valid <= w_done;
            if (w_done) r_fdata <= r_shift;
            if (w_pop) r_exp <= w_head;
            r_flags <= w_set | (r_flags & ~{4{clear_i}});
        end
    end
    uart_mon_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (wdata_qe_i),
        .pop_i  (w_pop),
        .data_i (wdata_i),
        .head_o (w_head),
        .full_o (w_full),
        .empty_o(w_empty)
    );
`ifdef UART_MON_STALL_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);
    logic [SW-1:0] r_stall_cnt;
    logic r_stall;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
            r_stall <= 1'b0;
        end else begin
            r_stall_cnt <= (tx_busy_i && r_state == IDLE) ?
                           r_stall_cnt + SW'(r_stall_cnt != SW'(STALL_LIMIT)) : '0;
            r_stall <= (r_stall_cnt == SW'(STALL_LIMIT)) || (r_stall && !clear_i);
        end
    end
    assign stall_o = r_stall;
`else
    logic w_unused_busy;
    assign w_unused_busy = tx_busy_i;
    assign stall_o = 1'b0;
`endif
    assign frame_valid_o = r_valid;
    assign frame_data_o = r_fdata;
    assign exp_data_o = r_exp;
    assign {mismatch_o, frame_err_o, unexpected_o, ovf_o} = r_flags;
    assign alert_o = |r_flags || stall_o;
endmodule

// File: doc/uart_tx_frame_monitor.md
UART_TX_FRAME_MONITOR -- requirements
Module: uart_tx_frame_monitor

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per UART bit (even, >=4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, expected-byte shadow entries (power of 2).
REQ-003 SHALL have parameter STALL_LIMIT, default 32, stall threshold in cycles.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wdata_i  input  8  byte written to the UART TX data register.
REQ-007 SHALL have port wdata_qe_i  input  1  one-cycle write strobe for wdata_i.
REQ-008 SHALL have port tx_i  input  1  serial TX line, same clock domain as clk_i.
REQ-009 SHALL have port tx_busy_i  input  1  transmitter busy indication.
REQ-010 SHALL have port clear_i  input  1  clears all sticky flags.
REQ-011 SHALL have port frame_valid_o  output  1  one-cycle pulse per decoded frame.
REQ-012 SHALL have port frame_data_o  output  8  last decoded byte.
REQ-013 SHALL have port exp_data_o  output  8  expected byte of the last compared frame.
REQ-014 SHALL have ports mismatch_o, frame_err_o, unexpected_o, ovf_o, stall_o  output  1 each  sticky flags.
REQ-015 SHALL have port alert_o  output  1  OR of all sticky flags.

Function
REQ-016 SHALL push wdata_i into the shadow FIFO on wdata_qe_i; push while full with no pop is dropped and sets ovf_o.
REQ-017 SHALL register tx_i once; a 1->0 transition of the registered value while in IDLE enters START.
REQ-018 FSM states IDLE, START, DATA, STOP; bit counter counts 0..CLKS_PER_BIT-1.
REQ-019 START SHALL sample at CLKS_PER_BIT/2 cycles; sampled 1 -> IDLE (glitch, no flag); 0 -> DATA.
REQ-020 DATA SHALL sample every CLKS_PER_BIT cycles, 8 bits, LSB first, then -> STOP.
REQ-021 STOP SHALL sample after CLKS_PER_BIT cycles; 0 sets frame_err_o; either value -> IDLE with frame_valid_o pulsed and frame_data_o updated in the same cycle.
REQ-022 On frame_valid_o, FIFO empty SHALL set unexpected_o; else pop head, drive exp_data_o, set mismatch_o if head != decoded byte.
REQ-023 Push and pop in the same cycle SHALL both succeed, including when full (no ovf_o) and when empty (pushed byte not compared until a later frame).
REQ-024 Stall counter SHALL increment each cycle tx_busy_i=1 while FSM is IDLE, reset to 0 otherwise, saturate at STALL_LIMIT; reaching STALL_LIMIT sets stall_o.
REQ-025 clear_i SHALL clear sticky flags next cycle; a set event in the same cycle wins.
REQ-026 alert_o SHALL be combinational OR of the sticky flags.

Reset
REQ-027 Reset SHALL force FSM to IDLE, FIFO empty, counters 0, registered tx to 1, all outputs 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no flag and no frame_valid_o.

Configuration
REQ-029 With UART_MON_STALL_EN defined the stall counter and stall_o logic SHALL be present; without it stall_o SHALL be constant 0 and no stall counter exists.

Structure
REQ-030 Package uart_mon_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-031 Shadow FIFO SHALL be sub-module uart_mon_fifo (push/pop/full/empty/head).

Verification
REQ-032 Write 0x55, drive 0x55 frame at 16 cycles/bit -> frame_valid_o pulse, frame_data_o=0x55, alert_o=0.
REQ-033 Write 0x55, drive 0x54 -> mismatch_o=1, exp_data_o=0x55, frame_data_o=0x54, alert_o=1; clear_i -> all 0.
REQ-034 Drive 0xA5 frame with FIFO empty -> unexpected_o=1; stop bit forced 0 on next frame -> frame_err_o=1.
REQ-035 Five writes with no frames -> ovf_o=1; four following matching frames -> no mismatch_o.
REQ-036 tx_busy_i=1, tx_i=1 held 32 cycles -> stall_o=1 (macro defined), stall_o=0 (undefined); 4-cycle low pulse on tx_i -> no frame.
REQ-037 rst_ni low during DATA bit 3 -> FSM IDLE, no flags, next clean frame decodes correctly.
